// File: rtl/rr_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_output_arbiter
//  Purpose  : Per-output-port round-robin arbiter. Locks onto one input FIFO
//             for a whole packet, pops it under downstream credit control, and
//             drives the crossbar select/valid aligned to registered FIFO data.
//  Revision : 1.0  initial release
// ============================================================================
module rr_output_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int PKT_FLITS = 4,
    parameter int CREDITS   = 8,
    parameter int SELW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CW        = $clog2(CREDITS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               credit_in,
    output logic [NUM_REQ-1:0] rd_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [CW-1:0]      credit_cnt,
    output logic               busy
);

    localparam int              FCW         = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [FCW-1:0]  C_LAST_FLIT = FCW'(PKT_FLITS - 1);
    localparam logic [CW-1:0]   C_CREDITS   = CW'(CREDITS);
    localparam logic [SELW-1:0] C_PTR_RST   = SELW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_REQ-1:0] r_grant;
    logic [SELW-1:0]    r_owner;
    logic [SELW-1:0]    r_ptr;
    logic [FCW-1:0]     r_flit_cnt;
    logic [CW-1:0]      r_credit_cnt;
    logic [SELW-1:0]    r_sel;
    logic               r_out_valid;

    logic [SELW-1:0]    w_win;
    logic [SELW-1:0]    w_idx;
    logic               w_found;
    logic               w_pop;
    logic               w_last;

    // Circular search upward from ptr+1; the last winner is checked last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = SELW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Pop only while the owner still has data and downstream has a free slot.
    always_comb begin
        w_pop  = (r_state == XFER) && req[r_owner] && (r_credit_cnt != '0);
        w_last = w_pop && (r_flit_cnt == C_LAST_FLIT);
        rd_en  = w_pop ? r_grant : '0;
    end

    // Next-state: lock on a grant, release after the final flit of the packet.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = XFER;
            XFER:    if (w_last)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ownership, flit counting and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_flit_cnt <= '0;
            r_ptr      <= C_PTR_RST;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_grant    <= NUM_REQ'(1) << w_win;
                r_owner    <= w_win;
                r_flit_cnt <= '0;
            end
        end else if (w_pop) begin
            if (w_last) begin
                r_grant    <= '0;
                r_ptr      <= r_owner;
                r_flit_cnt <= '0;
            end else begin
                r_flit_cnt <= r_flit_cnt + 1'b1;
            end
        end
    end

    // Downstream credit tracking; a pop and a returned credit cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit_cnt <= C_CREDITS;
        end else if (w_pop && !credit_in) begin
            r_credit_cnt <= r_credit_cnt - 1'b1;
        end else if (credit_in && !w_pop && (r_credit_cnt != C_CREDITS)) begin
            r_credit_cnt <= r_credit_cnt + 1'b1;
        end
    end

    // Crossbar select/valid delayed one cycle to match the FIFO's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sel       <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_sel <= r_owner;
            end
        end
    end

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign out_valid  = r_out_valid;
    assign credit_cnt = r_credit_cnt;
    assign busy       = (r_state == XFER);

endmodule
`default_nettype wire
